acq_sequencer: RTL and testbench

//  Run controller for the pulse-registration / time-stamping datapath. Drives the

---
 rtl/acq_sequencer_if.sv | 23 ++
 rtl/acq_sequencer.sv | 128 ++++++++++++
 tb/tb_acq_sequencer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/acq_sequencer_if.sv
// Record bus between the acquisition sequencer, the registration block and the record FIFO.
// The sequencer takes the master side; the registration block and FIFO model take the slave side.
interface acq_sequencer_if #(
    parameter int REC_W = 47
);
    logic             reg_ready;
    logic [REC_W-1:0] reg_data;
    logic             reg_clear;
    logic             reg_operate;
    logic             fifo_full;
    logic             fifo_wr;
    logic [REC_W-1:0] fifo_din;

    modport master (
        input  reg_ready, reg_data, fifo_full,
        output reg_clear, reg_operate, fifo_wr, fifo_din
    );

    modport slave (
        output reg_ready, reg_data, fifo_full,
        input  reg_clear, reg_operate, fifo_wr, fifo_din
    );
endinterface

// File: rtl/acq_sequencer.sv
// Run controller for the pulse-registration datapath: sequences IDLE/CLEAR/RUN, moves
// ready records into the record FIFO, and keeps written/dropped counts plus an overrun flag.
module acq_sequencer #(
    parameter int REC_W      = 47,
    parameter int LOST_BIT   = 44,
    parameter int CNT_W      = 32,
    parameter int CLR_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
    input  logic             limit_en,
    input  logic [CNT_W-1:0] rec_limit,
    acq_sequencer_if.master  bus,
    output logic             busy,
    output logic [CNT_W-1:0] rec_count,
    output logic [CNT_W-1:0] lost_count,
    output logic             overrun
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [3:0]       CLR_LAST = 4'(CLR_CYCLES - 1);

    state_t           state;
    logic [3:0]       clr_cnt;
    logic             limit_en_q;
    logic [CNT_W-1:0] limit_q;
    logic             pending_lost;

    logic             accept;
    logic             drop;
    logic [CNT_W-1:0] rec_next;
    logic [CNT_W-1:0] lost_next;
    logic             limit_hit;

    // Records only count in RUN; the stop cycle still belongs to RUN.
    always_comb begin
        accept    = (state == RUN) && bus.reg_ready && !bus.fifo_full;
        drop      = (state == RUN) && bus.reg_ready &&  bus.fifo_full;
        rec_next  = (rec_count  == CNT_MAX) ? rec_count  : rec_count  + CNT_W'(1);
        lost_next = (lost_count == CNT_MAX) ? lost_count : lost_count + CNT_W'(1);
        limit_hit = accept && limit_en_q && (limit_q != '0) && (rec_next == limit_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            clr_cnt         <= '0;
            limit_en_q      <= 1'b0;
            limit_q         <= '0;
            pending_lost    <= 1'b0;
            rec_count       <= '0;
            lost_count      <= '0;
            overrun         <= 1'b0;
            busy            <= 1'b0;
            bus.reg_clear   <= 1'b1;
            bus.reg_operate <= 1'b0;
            bus.fifo_wr     <= 1'b0;
            bus.fifo_din    <= '0;
        end else begin
            bus.fifo_wr <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        state        <= CLEAR;
                        clr_cnt      <= '0;
                        limit_en_q   <= limit_en;
                        limit_q      <= rec_limit;
                        rec_count    <= '0;
                        lost_count   <= '0;
                        overrun      <= 1'b0;
                        pending_lost <= 1'b0;
                        busy         <= 1'b1;
                    end
                end

                CLEAR: begin
                    if (stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (clr_cnt == CLR_LAST) begin
                        state           <= RUN;
                        bus.reg_clear   <= 1'b0;
                        bus.reg_operate <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + 4'd1;
                    end
                end

                RUN: begin
                    if (accept) begin
                        bus.fifo_wr  <= 1'b1;
                        bus.fifo_din <= bus.reg_data | (REC_W'(pending_lost) << LOST_BIT);
                        pending_lost <= 1'b0;
                        rec_count    <= rec_next;
                    end
                    if (drop) begin
                        lost_count   <= lost_next;
                        pending_lost <= 1'b1;
                        overrun      <= 1'b1;
                    end
                    // Outputs are registered alongside the state so they flip on the same edge.
                    if (stop || limit_hit) begin
                        state           <= IDLE;
                        busy            <= 1'b0;
                        bus.reg_clear   <= 1'b1;
                        bus.reg_operate <= 1'b0;
                    end
                end

                default: begin
                    state           <= IDLE;
                    busy            <= 1'b0;
                    bus.reg_clear   <= 1'b1;
                    bus.reg_operate <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acq_sequencer.sv
// Directed bench for acq_sequencer; counters are narrowed to 4 bits so saturation is reachable.
module tb_acq_sequencer;

    localparam int REC_W      = 47;
    localparam int LOST_BIT   = 44;
    localparam int CNT_W      = 4;
    localparam int CLR_CYCLES = 4;

    logic             clk;
    logic             reset_n;
    logic             start;
    logic             stop;
    logic             limit_en;
    logic [CNT_W-1:0] rec_limit;
    logic             busy;
    logic [CNT_W-1:0] rec_count;
    logic [CNT_W-1:0] lost_count;
    logic             overrun;

    int test_count = 0;
    int fail_count = 0;

    acq_sequencer_if #(.REC_W(REC_W)) bus ();

    acq_sequencer #(
        .REC_W(REC_W), .LOST_BIT(LOST_BIT), .CNT_W(CNT_W), .CLR_CYCLES(CLR_CYCLES)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
        .limit_en(limit_en), .rec_limit(rec_limit), .bus(bus),
        .busy(busy), .rec_count(rec_count), .lost_count(lost_count), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, then settle 1ns past the edge so outputs reflect it.
    task automatic applyStimulus(input logic st, input logic sp, input logic rdy,
                                 input logic [REC_W-1:0] d, input logic full);
        start         = st;
        stop          = sp;
        bus.reg_ready = rdy;
        bus.reg_data  = d;
        bus.fifo_full = full;
        @(posedge clk);
        #1;
    endtask

    task automatic start_run();
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
        repeat (CLR_CYCLES) applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_count++; if (bus.reg_clear !== 1'b1) begin fail_count++; $display("[TB] FAIL rst_reg_clear: got %b expected 1", bus.reg_clear); end
        test_count++; if (bus.reg_operate !== 1'b0) begin fail_count++; $display("[TB] FAIL rst_reg_operate: got %b expected 0", bus.reg_operate); end
        test_count++; if (bus.fifo_wr !== 1'b0) begin fail_count++; $display("[TB] FAIL rst_fifo_wr: got %b expected 0", bus.fifo_wr); end
        test_count++; if (bus.fifo_din !== 47'h0) begin fail_count++; $display("[TB] FAIL rst_fifo_din: got %h expected 0", bus.fifo_din); end
        test_count++; if (busy !== 1'b0) begin fail_count++; $display("[TB] FAIL rst_busy: got %b expected 0", busy); end
        test_count++; if (rec_count !== 4'd0 || lost_count !== 4'd0 || overrun !== 1'b0) begin fail_count++; $display("[TB] FAIL rst_counters: got rec=%0d lost=%0d ovr=%b expected 0 0 0", rec_count, lost_count, overrun); end
        reset_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
        test_count++; if (busy !== 1'b0 || bus.reg_clear !== 1'b1) begin fail_count++; $display("[TB] FAIL idle_hold: got busy=%b clr=%b expected 0 1", busy, bus.reg_clear); end
    endtask

    task automatic test_clear();
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
        test_count++; if (busy !== 1'b1 || bus.reg_clear !== 1'b1 || bus.reg_operate !== 1'b0) begin fail_count++; $display("[TB] FAIL clear_enter: got busy=%b clr=%b op=%b expected 1 1 0", busy, bus.reg_clear, bus.reg_operate); end
        for (int i = 1; i < CLR_CYCLES; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 47'hAA, 1'b0);
            test_count++; if (bus.reg_clear !== 1'b1 || bus.fifo_wr !== 1'b0) begin fail_count++; $display("[TB] FAIL clear_cycle%0d: got clr=%b wr=%b expected 1 0", i, bus.reg_clear, bus.fifo_wr); end
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 47'hAA, 1'b0);
        test_count++; if (bus.reg_clear !== 1'b0 || bus.reg_operate !== 1'b1 || busy !== 1'b1) begin fail_count++; $display("[TB] FAIL run_enter: got clr=%b op=%b busy=%b expected 0 1 1", bus.reg_clear, bus.reg_operate, busy); end
        test_count++; if (bus.fifo_wr !== 1'b0 || rec_count !== 4'd0 || lost_count !== 4'd0) begin fail_count++; $display("[TB] FAIL clear_discard: got wr=%b rec=%0d lost=%0d expected 0 0 0", bus.fifo_wr, rec_count, lost_count); end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, REC_W'(i), 1'b0);
            test_count++; if (bus.fifo_wr !== 1'b1 || bus.fifo_din !== REC_W'(i)) begin fail_count++; $display("[TB] FAIL b2b_rec%0d: got wr=%b din=%h expected 1 %h", i, bus.fifo_wr, bus.fifo_din, REC_W'(i)); end
            test_count++; if (rec_count !== 4'(i)) begin fail_count++; $display("[TB] FAIL b2b_count%0d: got %0d expected %0d", i, rec_count, i); end
        end
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
        test_count++; if (bus.fifo_wr !== 1'b0 || rec_count !== 4'd3) begin fail_count++; $display("[TB] FAIL b2b_after: got wr=%b rec=%0d expected 0 3", bus.fifo_wr, rec_count); end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 2; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 47'h9, 1'b1);
            test_count++; if (bus.fifo_wr !== 1'b0 || lost_count !== 4'(i) || overrun !== 1'b1) begin fail_count++; $display("[TB] FAIL drop%0d: got wr=%b lost=%0d ovr=%b expected 0 %0d 1", i, bus.fifo_wr, lost_count, overrun, i); end
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 47'h5, 1'b0);
        test_count++; if (bus.fifo_wr !== 1'b1 || bus.fifo_din !== 47'h1000_0000_0005) begin fail_count++; $display("[TB] FAIL lost_flag: got wr=%b din=%h expected 1 100000000005", bus.fifo_wr, bus.fifo_din); end
        applyStimulus(1'b0, 1'b0, 1'b1, 47'h6, 1'b0);
        test_count++; if (bus.fifo_din !== 47'h6 || rec_count !== 4'd5) begin fail_count++; $display("[TB] FAIL lost_flag_clear: got din=%h rec=%0d expected 6 5", bus.fifo_din, rec_count); end
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0);
        test_count++; if (busy !== 1'b0 || bus.reg_clear !== 1'b1 || bus.reg_operate !== 1'b0) begin fail_count++; $display("[TB] FAIL stop_run: got busy=%b clr=%b op=%b expected 0 1 0", busy, bus.reg_clear, bus.reg_operate); end
        applyStimulus(1'b0, 1'b0, 1'b1, 47'h7, 1'b1);
        test_count++; if (rec_count !== 4'd5 || lost_count !== 4'd2 || overrun !== 1'b1) begin fail_count++; $display("[TB] FAIL idle_counters_hold: got rec=%0d lost=%0d ovr=%b expected 5 2 1", rec_count, lost_count, overrun); end
    endtask

    task automatic test_limit();
        limit_en  = 1'b1;
        rec_limit = 4'd2;
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
        test_count++; if (rec_count !== 4'd0 || lost_count !== 4'd0 || overrun !== 1'b0) begin fail_count++; $display("[TB] FAIL start_zero: got rec=%0d lost=%0d ovr=%b expected 0 0 0", rec_count, lost_count, overrun); end
        limit_en  = 1'b0;
        rec_limit = 4'd0;
        repeat (CLR_CYCLES) applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 47'h11, 1'b0);
        test_count++; if (bus.fifo_wr !== 1'b1 || rec_count !== 4'd1 || busy !== 1'b1) begin fail_count++; $display("[TB] FAIL limit_rec1: got wr=%b rec=%0d busy=%b expected 1 1 1", bus.fifo_wr, rec_count, busy); end
        applyStimulus(1'b0, 1'b0, 1'b1, 47'h12, 1'b0);
        test_count++; if (bus.fifo_wr !== 1'b1 || bus.fifo_din !== 47'h12 || rec_count !== 4'd2) begin fail_count++; $display("[TB] FAIL limit_rec2: got wr=%b din=%h rec=%0d expected 1 12 2", bus.fifo_wr, bus.fifo_din, rec_count); end
        test_count++; if (busy !== 1'b0 || bus.reg_clear !== 1'b1) begin fail_count++; $display("[TB] FAIL limit_idle: got busy=%b clr=%b expected 0 1", busy, bus.reg_clear); end
        applyStimulus(1'b0, 1'b0, 1'b1, 47'h13, 1'b0);
        test_count++; if (bus.fifo_wr !== 1'b0 || rec_count !== 4'd2 || bus.fifo_din !== 47'h12) begin fail_count++; $display("[TB] FAIL limit_rec3: got wr=%b rec=%0d din=%h expected 0 2 12", bus.fifo_wr, rec_count, bus.fifo_din); end
    endtask

    task automatic test_start_stop();
        applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0);
        test_count++; if (busy !== 1'b0 || rec_count !== 4'd2) begin fail_count++; $display("[TB] FAIL start_stop_idle: got busy=%b rec=%0d expected 0 2", busy, rec_count); end
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0);
        repeat (CLR_CYCLES) applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
        test_count++; if (busy !== 1'b0 || bus.reg_operate !== 1'b0) begin fail_count++; $display("[TB] FAIL stop_in_clear: got busy=%b op=%b expected 0 0", busy, bus.reg_operate); end
        start_run();
        applyStimulus(1'b0, 1'b1, 1'b1, 47'h21, 1'b0);
        test_count++; if (bus.fifo_wr !== 1'b1 || bus.fifo_din !== 47'h21 || rec_count !== 4'd1) begin fail_count++; $display("[TB] FAIL stop_rec: got wr=%b din=%h rec=%0d expected 1 21 1", bus.fifo_wr, bus.fifo_din, rec_count); end
        test_count++; if (busy !== 1'b0 || bus.reg_operate !== 1'b0) begin fail_count++; $display("[TB] FAIL stop_rec_idle: got busy=%b op=%b expected 0 0", busy, bus.reg_operate); end
        applyStimulus(1'b0, 1'b0, 1'b1, 47'h22, 1'b0);
        test_count++; if (bus.fifo_wr !== 1'b0 || rec_count !== 4'd1) begin fail_count++; $display("[TB] FAIL idle_no_rec: got wr=%b rec=%0d expected 0 1", bus.fifo_wr, rec_count); end
    endtask

    task automatic test_saturation();
        logic [CNT_W-1:0] exp_cnt;
        logic [REC_W-1:0] exp_din;
        start_run();
        for (int k = 1; k <= 17; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 47'hBAD, 1'b1);
            exp_cnt = (k < 15) ? 4'(k) : 4'hF;
            test_count++; if (lost_count !== exp_cnt || bus.fifo_wr !== 1'b0) begin fail_count++; $display("[TB] FAIL lost_sat%0d: got lost=%0d wr=%b expected %0d 0", k, lost_count, bus.fifo_wr, exp_cnt); end
        end
        for (int k = 1; k <= 17; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, REC_W'(256 + k), 1'b0);
            exp_cnt = (k < 15) ? 4'(k) : 4'hF;
            exp_din = REC_W'(256 + k) | ((k == 1) ? (47'h1 << LOST_BIT) : 47'h0);
            test_count++; if (rec_count !== exp_cnt || bus.fifo_din !== exp_din) begin fail_count++; $display("[TB] FAIL rec_sat%0d: got rec=%0d din=%h expected %0d %h", k, rec_count, bus.fifo_din, exp_cnt, exp_din); end
        end
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0);
    endtask

    task automatic test_reset_mid_run();
        start_run();
        applyStimulus(1'b0, 1'b0, 1'b1, 47'h77, 1'b0);
        test_count++; if (bus.fifo_wr !== 1'b1 || rec_count !== 4'd1) begin fail_count++; $display("[TB] FAIL pre_reset_wr: got wr=%b rec=%0d expected 1 1", bus.fifo_wr, rec_count); end
        reset_n = 1'b0;
        #2;
        test_count++; if (bus.fifo_wr !== 1'b0 || bus.reg_clear !== 1'b1 || bus.reg_operate !== 1'b0) begin fail_count++; $display("[TB] FAIL async_reset_ctl: got wr=%b clr=%b op=%b expected 0 1 0", bus.fifo_wr, bus.reg_clear, bus.reg_operate); end
        test_count++; if (rec_count !== 4'd0 || busy !== 1'b0 || bus.fifo_din !== 47'h0) begin fail_count++; $display("[TB] FAIL async_reset_data: got rec=%0d busy=%b din=%h expected 0 0 0", rec_count, busy, bus.fifo_din); end
        applyStimulus(1'b0, 1'b0, 1'b1, 47'h78, 1'b0);
        reset_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1, 47'h79, 1'b0);
        test_count++; if (bus.fifo_wr !== 1'b0 || busy !== 1'b0) begin fail_count++; $display("[TB] FAIL post_reset_idle: got wr=%b busy=%b expected 0 0", bus.fifo_wr, busy); end
    endtask

    initial begin
        reset_n       = 1'b0;
        start         = 1'b0;
        stop          = 1'b0;
        limit_en      = 1'b0;
        rec_limit     = '0;
        bus.reg_ready = 1'b0;
        bus.reg_data  = '0;
        bus.fifo_full = 1'b0;
        test_reset();
        test_clear();
        test_back_to_back();
        test_overflow();
        test_limit();
        test_start_stop();
        test_saturation();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
